// File: rtl/csc_pipe_if.sv
// Pixel beat bundle: valid/ready handshake, direction, end-of-block marker
// and three DW-bit components. The producer side drives the beat and the
// consumer side drives ready.
interface csc_pipe_if #(
   parameter int DW = 8
);
   logic          vld;
   logic          rdy;
   logic          mode;
   logic          last;
   logic [DW-1:0] c0;
   logic [DW-1:0] c1;
   logic [DW-1:0] c2;

   modport master (output vld, mode, last, c0, c1, c2, input rdy);
   modport slave  (input vld, mode, last, c0, c1, c2, output rdy);
endinterface

// File: rtl/csc_pipe.sv
// Four-stage RGB <-> YCbCr (JFIF full range) converter with per-beat
// direction, rounding, saturation and a single global stall.
// Stages: operands -> products -> sums -> round/shift/offset/clamp.
module csc_pipe #(
   parameter int DW   = 8,
   parameter int FRAC = 14
) (
   input  logic       clk,
   input  logic       rstn,
   csc_pipe_if.slave  src,
   csc_pipe_if.master dst
);
   localparam int OW   = DW + 1;          // signed operand width
   localparam int CW   = FRAC + 2;        // signed coefficient width
   localparam int PW   = OW + CW;         // product width
   localparam int AW   = DW + FRAC + 4;   // accumulator width, overflow-free
   localparam int OFS  = 1 << (DW - 1);
   localparam int MAXV = (1 << DW) - 1;

   // Coefficient value in millionths; rows are outputs, columns are inputs.
   // Mode 1 uses 1.0 on the Y column so Y enters as Y*2^FRAC.
   function automatic longint coef_micro(input int m, input int r, input int c);
      case (m * 9 + r * 3 + c)
         0:  return 299000;
         1:  return 587000;
         2:  return 114000;
         3:  return -168736;
         4:  return -331264;
         5:  return 500000;
         6:  return 500000;
         7:  return -418688;
         8:  return -81312;
         9:  return 1000000;
         10: return 0;
         11: return 1402000;
         12: return 1000000;
         13: return -344136;
         14: return -714136;
         15: return 1000000;
         16: return 1772000;
         17: return 0;
         default: return 0;
      endcase
   endfunction

   // round(c * 2^FRAC) with rounding applied to the magnitude
   function automatic logic signed [CW-1:0] coef(input longint micro);
      longint mag;
      mag = (micro < 0) ? -micro : micro;
      mag = (mag * (longint'(1) << FRAC) + 500000) / 1000000;
      return CW'((micro < 0) ? -mag : mag);
   endfunction

   logic                 en;
   logic                 v1_reg, v2_reg, v3_reg, vo_reg;
   logic                 m1_reg, m2_reg, m3_reg;
   logic                 l1_reg, l2_reg, l3_reg;
   logic                 out_mode_reg, out_last_reg;
   logic [DW-1:0]        src_c [3];
   logic signed [OW-1:0] op_next [3];
   logic signed [OW-1:0] op_reg [3];
   logic signed [CW-1:0] k_sel [3][3];
   logic signed [PW-1:0] prod_reg [3][3];
   logic signed [AW-1:0] sum_reg [3];
   logic [DW-1:0]        sat [3];
   logic [DW-1:0]        out_reg [3];

   assign en      = dst.rdy | ~vo_reg;
   assign src.rdy = en;

   assign src_c[0] = src.c0;
   assign src_c[1] = src.c1;
   assign src_c[2] = src.c2;

   genvar gi, gj;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic signed [OW-1:0] ext;
         logic signed [AW-1:0] shf;
         logic signed [AW-1:0] adj;

         assign ext = $signed({1'b0, src_c[gi]});
         assign shf = (sum_reg[gi] + AW'(1 << (FRAC - 1))) >>> FRAC;

         // Y/R column is never offset; chroma is re-centred on input in
         // mode 1 and re-offset on output in mode 0.
         if (gi == 0) begin : g_luma
            assign op_next[gi] = ext;
            assign adj         = shf;
         end else begin : g_chroma
            assign op_next[gi] = src.mode ? (ext - OW'(OFS)) : ext;
            assign adj         = m3_reg ? shf : (shf + AW'(OFS));
         end

         assign sat[gi] = adj[AW-1] ? '0 :
                          ((adj > AW'(MAXV)) ? DW'(MAXV) : adj[DW-1:0]);

         for (gj = 0; gj < 3; gj++) begin : g_tap
            localparam logic signed [CW-1:0] KF = coef(coef_micro(0, gi, gj));
            localparam logic signed [CW-1:0] KI = coef(coef_micro(1, gi, gj));
            assign k_sel[gi][gj] = m1_reg ? KI : KF;
         end
      end
   endgenerate

   // Valid bits and the visible output beat; cleared by reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1_reg       <= 1'b0;
         v2_reg       <= 1'b0;
         v3_reg       <= 1'b0;
         vo_reg       <= 1'b0;
         out_mode_reg <= 1'b0;
         out_last_reg <= 1'b0;
         for (int i = 0; i < 3; i++) out_reg[i] <= '0;
      end else if (en) begin
         v1_reg <= src.vld;
         v2_reg <= v1_reg;
         v3_reg <= v2_reg;
         vo_reg <= v3_reg;
         if (v3_reg) begin
            out_mode_reg <= m3_reg;
            out_last_reg <= l3_reg;
            for (int i = 0; i < 3; i++) out_reg[i] <= sat[i];
         end
      end
   end

   // Datapath registers; contents are meaningless while their valid is low.
   always_ff @(posedge clk) begin
      if (en) begin
         m1_reg <= src.mode;
         l1_reg <= src.last;
         m2_reg <= m1_reg;
         l2_reg <= l1_reg;
         m3_reg <= m2_reg;
         l3_reg <= l2_reg;
         for (int i = 0; i < 3; i++) begin
            op_reg[i]  <= op_next[i];
            sum_reg[i] <= AW'(prod_reg[i][0]) + AW'(prod_reg[i][1]) + AW'(prod_reg[i][2]);
            for (int j = 0; j < 3; j++)
               prod_reg[i][j] <= PW'(op_reg[j]) * PW'(k_sel[i][j]);
         end
      end
   end

   assign dst.vld  = vo_reg;
   assign dst.mode = out_mode_reg;
   assign dst.last = out_last_reg;
   assign dst.c0   = out_reg[0];
   assign dst.c1   = out_reg[1];
   assign dst.c2   = out_reg[2];
endmodule

// File: tb/tb_csc_pipe.sv
// Bench for csc_pipe: directed vectors, streaming, backpressure, mid-stream
// reset and a DW=10/FRAC=12 instance, all against an equation-level model.
module tb_csc_pipe;
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   csc_pipe_if #(.DW(8))  a_src ();
   csc_pipe_if #(.DW(8))  a_dst ();
   csc_pipe_if #(.DW(10)) b_src ();
   csc_pipe_if #(.DW(10)) b_dst ();

   csc_pipe #(.DW(8), .FRAC(14)) dut_a (.clk(clk), .rstn(rstn), .src(a_src.slave), .dst(a_dst.master));
   csc_pipe #(.DW(10), .FRAC(12)) dut_b (.clk(clk), .rstn(rstn), .src(b_src.slave), .dst(b_dst.master));

   typedef struct {
      bit mode;
      bit last;
      int c0, c1, c2;
   } beat_t;

   int checks = 0;
   int errors = 0;
   int rgb [1000][3];
   int ycc [1000][3];

   function automatic longint kq(real c, int frac);
      return longint'($floor(c * (2.0 ** frac) + 0.5));
   endfunction

   function automatic int fin(longint s, int frac, int dw, int add);
      longint v;
      v = ((s + (longint'(1) << (frac - 1))) >>> frac) + add;
      if (v < 0) return 0;
      if (v > (1 << dw) - 1) return (1 << dw) - 1;
      return int'(v);
   endfunction

   function automatic beat_t model(int dw, int frac, bit mode, bit last, int a, int b, int c);
      beat_t  r;
      int     ofs = 1 << (dw - 1);
      longint one = longint'(1) << frac;
      r.mode = mode;
      r.last = last;
      if (!mode) begin
         r.c0 = fin(kq(0.299, frac) * a + kq(0.587, frac) * b + kq(0.114, frac) * c, frac, dw, 0);
         r.c1 = fin(-kq(0.168736, frac) * a - kq(0.331264, frac) * b + kq(0.5, frac) * c, frac, dw, ofs);
         r.c2 = fin(kq(0.5, frac) * a - kq(0.418688, frac) * b - kq(0.081312, frac) * c, frac, dw, ofs);
      end else begin
         r.c0 = fin(one * a + kq(1.402, frac) * (c - ofs), frac, dw, 0);
         r.c1 = fin(one * a - kq(0.344136, frac) * (b - ofs) - kq(0.714136, frac) * (c - ofs), frac, dw, 0);
         r.c2 = fin(one * a + kq(1.772, frac) * (b - ofs), frac, dw, 0);
      end
      return r;
   endfunction

   task automatic test_reset();
      rstn = 1'b0;
      a_src.vld = 0; a_src.mode = 0; a_src.last = 0; a_src.c0 = 0; a_src.c1 = 0; a_src.c2 = 0;
      b_src.vld = 0; b_src.mode = 0; b_src.last = 0; b_src.c0 = 0; b_src.c1 = 0; b_src.c2 = 0;
      a_dst.rdy = 0; b_dst.rdy = 0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({a_dst.vld, a_src.rdy, a_dst.mode, a_dst.last, a_dst.c0, a_dst.c1, a_dst.c2} !== {1'b0, 1'b1, 2'b00, 24'h0}) begin
         errors++;
         $display("FAIL reset_state: vld=%b rdy=%b mode=%b last=%b c=%0d,%0d,%0d required 0,1,0,0,0,0,0",
                  a_dst.vld, a_src.rdy, a_dst.mode, a_dst.last, a_dst.c0, a_dst.c1, a_dst.c2);
      end
      $display("reset: vld=%b rdy=%b", a_dst.vld, a_src.rdy);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (a_dst.vld !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: cycle %0d vld=%b required 0", i, a_dst.vld);
         end
      end
   endtask

   task automatic test_vectors();
      int v [5][7] = '{'{0, 255, 255, 255, 255, 128, 128},
                       '{0,   0,   0,   0,   0, 128, 128},
                       '{0, 255,   0,   0,  76,  85, 255},
                       '{1, 255, 128, 128, 255, 255, 255},
                       '{1,   0, 255, 128,   0,   0, 225}};
      int n;
      a_dst.rdy = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a_src.vld = 1; a_src.mode = v[k][0][0]; a_src.last = k[0];
         a_src.c0 = 8'(v[k][1]); a_src.c1 = 8'(v[k][2]); a_src.c2 = 8'(v[k][3]);
         @(negedge clk);
         a_src.vld = 0;
         n = 0;
         while (!a_dst.vld && n < 10) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (!a_dst.vld) begin
            errors++;
            $display("FAIL vector_%0d timeout: vld=0 required 1", k);
         end else if ({a_dst.mode, a_dst.last, a_dst.c0, a_dst.c1, a_dst.c2} !==
                      {v[k][0][0], k[0], 8'(v[k][4]), 8'(v[k][5]), 8'(v[k][6])}) begin
            errors++;
            $display("FAIL vector_%0d: got %0d,%0d,%0d m%b l%b required %0d,%0d,%0d m%b l%b", k,
                     a_dst.c0, a_dst.c1, a_dst.c2, a_dst.mode, a_dst.last,
                     v[k][4], v[k][5], v[k][6], v[k][0][0], k[0]);
         end
         $display("vector %0d: mode=%0d in=%0d,%0d,%0d out=%0d,%0d,%0d", k, v[k][0],
                  v[k][1], v[k][2], v[k][3], a_dst.c0, a_dst.c1, a_dst.c2);
      end
   endtask

   task automatic test_streaming();
      beat_t q [$];
      beat_t e;
      int sent = 0, got = 0, cyc = 0, first_acc = -1, first_vld = -1;
      a_dst.rdy = 1;
      while ((sent < 64 || q.size() != 0) && cyc < 200) begin
         @(negedge clk);
         if (a_dst.vld) begin
            if (first_vld < 0) first_vld = cyc;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL stream_extra_beat: vld=1 with nothing expected");
            end else begin
               e = q.pop_front();
               if ({a_dst.mode, a_dst.last, a_dst.c0, a_dst.c1, a_dst.c2} !==
                   {e.mode, e.last, 8'(e.c0), 8'(e.c1), 8'(e.c2)}) begin
                  errors++;
                  $display("FAIL stream_beat_%0d: got %0d,%0d,%0d m%b l%b required %0d,%0d,%0d m%b l%b", got,
                           a_dst.c0, a_dst.c1, a_dst.c2, a_dst.mode, a_dst.last, e.c0, e.c1, e.c2, e.mode, e.last);
               end
               $display("stream beat %0d: m%b l%b out=%0d,%0d,%0d", got, a_dst.mode, a_dst.last,
                        a_dst.c0, a_dst.c1, a_dst.c2);
               got++;
            end
         end
         if (sent < 64) begin
            a_src.vld = 1; a_src.mode = sent[0]; a_src.last = 1'($urandom);
            a_src.c0 = 8'($urandom); a_src.c1 = 8'($urandom); a_src.c2 = 8'($urandom);
            q.push_back(model(8, 14, a_src.mode, a_src.last, a_src.c0, a_src.c1, a_src.c2));
            if (first_acc < 0) first_acc = cyc;
            sent++;
         end else begin
            a_src.vld = 0;
         end
         cyc++;
      end
      a_src.vld = 0;
      checks++;
      if (got != 64) begin
         errors++;
         $display("FAIL stream_count: got %0d beats required 64", got);
      end
      checks++;
      if (first_vld - first_acc != 4) begin
         errors++;
         $display("FAIL stream_latency: %0d cycles required 4", first_vld - first_acc);
      end
   endtask

   task automatic test_backpressure();
      beat_t q [$];
      beat_t e;
      logic [26:0] prev = '0;
      bit stalled = 0, rdy, vld;
      int cyc = 0, acc = 0, got = 0;
      while (cyc < 300 || (q.size() != 0 && cyc < 400)) begin
         @(negedge clk);
         if (stalled) begin
            checks++;
            if ({a_dst.vld, a_dst.mode, a_dst.last, a_dst.c0, a_dst.c1, a_dst.c2} !== prev) begin
               errors++;
               $display("FAIL bp_hold: outputs %h required %h", {a_dst.vld, a_dst.mode, a_dst.last,
                        a_dst.c0, a_dst.c1, a_dst.c2}, prev);
            end
         end
         rdy = (cyc < 300) ? 1'($urandom) : 1'b1;
         vld = (cyc < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
         a_dst.rdy = rdy;
         a_src.vld = vld; a_src.mode = 1'($urandom); a_src.last = 1'($urandom);
         a_src.c0 = 8'($urandom); a_src.c1 = 8'($urandom); a_src.c2 = 8'($urandom);
         #1;
         checks++;
         if (a_src.rdy !== (rdy | ~a_dst.vld)) begin
            errors++;
            $display("FAIL bp_rdy: rdy_o=%b required %b", a_src.rdy, rdy | ~a_dst.vld);
         end
         if (a_dst.vld && rdy) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL bp_extra_beat: emitted with nothing expected");
            end else begin
               e = q.pop_front();
               if ({a_dst.mode, a_dst.last, a_dst.c0, a_dst.c1, a_dst.c2} !==
                   {e.mode, e.last, 8'(e.c0), 8'(e.c1), 8'(e.c2)}) begin
                  errors++;
                  $display("FAIL bp_beat_%0d: got %0d,%0d,%0d m%b l%b required %0d,%0d,%0d m%b l%b", got,
                           a_dst.c0, a_dst.c1, a_dst.c2, a_dst.mode, a_dst.last, e.c0, e.c1, e.c2, e.mode, e.last);
               end
            end
            $display("bp beat %0d: out=%0d,%0d,%0d", got, a_dst.c0, a_dst.c1, a_dst.c2);
            got++;
         end
         if (vld && (rdy || !a_dst.vld)) begin
            q.push_back(model(8, 14, a_src.mode, a_src.last, a_src.c0, a_src.c1, a_src.c2));
            acc++;
         end
         stalled = a_dst.vld && !rdy;
         prev = {a_dst.vld, a_dst.mode, a_dst.last, a_dst.c0, a_dst.c1, a_dst.c2};
         cyc++;
      end
      a_src.vld = 0;
      a_dst.rdy = 1;
      checks++;
      if (q.size() != 0 || got != acc) begin
         errors++;
         $display("FAIL bp_count: emitted %0d accepted %0d pending %0d required equal and 0 pending",
                  got, acc, q.size());
      end
   endtask

   task automatic test_reset_midstream();
      beat_t q [$];
      beat_t e;
      int got = 0, first = -1;
      a_dst.rdy = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 3) begin
            a_src.vld = 1; a_src.mode = 0; a_src.last = 0;
            a_src.c0 = 8'($urandom); a_src.c1 = 8'($urandom); a_src.c2 = 8'($urandom);
         end else begin
            a_src.vld = 0;
         end
      end
      checks++;
      if (a_dst.vld !== 1'b1) begin
         errors++;
         $display("FAIL midrst_busy: vld=%b required 1 before reset", a_dst.vld);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({a_dst.vld, a_dst.mode, a_dst.last, a_dst.c0, a_dst.c1, a_dst.c2} !== 27'h0) begin
         errors++;
         $display("FAIL midrst_clear: vld=%b c=%0d,%0d,%0d required all 0", a_dst.vld,
                  a_dst.c0, a_dst.c1, a_dst.c2);
      end
      $display("midstream reset: vld=%b", a_dst.vld);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (a_dst.vld) begin
            if (first < 0) first = cyc;
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL midrst_stale_beat: out=%0d,%0d,%0d required no beat", a_dst.c0, a_dst.c1, a_dst.c2);
            end else begin
               e = q.pop_front();
               if ({a_dst.mode, a_dst.last, a_dst.c0, a_dst.c1, a_dst.c2} !==
                   {e.mode, e.last, 8'(e.c0), 8'(e.c1), 8'(e.c2)}) begin
                  errors++;
                  $display("FAIL midrst_beat_%0d: got %0d,%0d,%0d required %0d,%0d,%0d", got,
                           a_dst.c0, a_dst.c1, a_dst.c2, e.c0, e.c1, e.c2);
               end
            end
            $display("post-reset beat %0d: out=%0d,%0d,%0d", got, a_dst.c0, a_dst.c1, a_dst.c2);
            got++;
         end
         if (cyc < 2) begin
            a_src.vld = 1; a_src.mode = 1; a_src.last = 1;
            a_src.c0 = 8'($urandom); a_src.c1 = 8'($urandom); a_src.c2 = 8'($urandom);
            q.push_back(model(8, 14, 1'b1, 1'b1, a_src.c0, a_src.c1, a_src.c2));
         end else begin
            a_src.vld = 0;
         end
      end
      checks++;
      if (got != 2 || first != 4) begin
         errors++;
         $display("FAIL midrst_new_beats: count %0d first at %0d required 2 at 4", got, first);
      end
   endtask

   task automatic test_param_sweep();
      beat_t e;
      int n, sent, got, cyc, d0, d1, d2;
      b_dst.rdy = 1;
      @(negedge clk);
      b_src.vld = 1; b_src.mode = 0; b_src.last = 0;
      b_src.c0 = 10'd1023; b_src.c1 = 10'd1023; b_src.c2 = 10'd1023;
      @(negedge clk);
      b_src.vld = 0;
      n = 0;
      while (!b_dst.vld && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({b_dst.vld, b_dst.c0, b_dst.c1, b_dst.c2} !== {1'b1, 10'd1023, 10'd512, 10'd512}) begin
         errors++;
         $display("FAIL sweep_white: vld=%b got %0d,%0d,%0d required 1,1023,512,512",
                  b_dst.vld, b_dst.c0, b_dst.c1, b_dst.c2);
      end
      $display("sweep white: out=%0d,%0d,%0d", b_dst.c0, b_dst.c1, b_dst.c2);
      for (int i = 0; i < 1000; i++) begin
         for (int c = 0; c < 3; c++) rgb[i][c] = $urandom_range(0, 1023);
         e = model(10, 12, 1'b0, 1'b0, rgb[i][0], rgb[i][1], rgb[i][2]);
         ycc[i][0] = e.c0; ycc[i][1] = e.c1; ycc[i][2] = e.c2;
      end
      for (int pass = 0; pass < 2; pass++) begin
         sent = 0; got = 0; cyc = 0;
         while (got < 1000 && cyc < 1100) begin
            @(negedge clk);
            if (b_dst.vld) begin
               checks++;
               if (pass == 0) begin
                  if ({b_dst.c0, b_dst.c1, b_dst.c2} !== {10'(ycc[got][0]), 10'(ycc[got][1]), 10'(ycc[got][2])}) begin
                     errors++;
                     $display("FAIL sweep_fwd_%0d: got %0d,%0d,%0d required %0d,%0d,%0d", got,
                              b_dst.c0, b_dst.c1, b_dst.c2, ycc[got][0], ycc[got][1], ycc[got][2]);
                  end
               end else begin
                  d0 = int'(b_dst.c0) - rgb[got][0];
                  d1 = int'(b_dst.c1) - rgb[got][1];
                  d2 = int'(b_dst.c2) - rgb[got][2];
                  if (d0 > 1 || d0 < -1 || d1 > 1 || d1 < -1 || d2 > 1 || d2 < -1) begin
                     errors++;
                     $display("FAIL sweep_roundtrip_%0d: got %0d,%0d,%0d required within 1 of %0d,%0d,%0d", got,
                              b_dst.c0, b_dst.c1, b_dst.c2, rgb[got][0], rgb[got][1], rgb[got][2]);
                  end
               end
               $display("sweep pass %0d beat %0d: out=%0d,%0d,%0d", pass, got, b_dst.c0, b_dst.c1, b_dst.c2);
               got++;
            end
            if (sent < 1000) begin
               b_src.vld = 1; b_src.mode = pass[0]; b_src.last = 0;
               if (pass == 0) begin
                  b_src.c0 = 10'(rgb[sent][0]); b_src.c1 = 10'(rgb[sent][1]); b_src.c2 = 10'(rgb[sent][2]);
               end else begin
                  b_src.c0 = 10'(ycc[sent][0]); b_src.c1 = 10'(ycc[sent][1]); b_src.c2 = 10'(ycc[sent][2]);
               end
               sent++;
            end else begin
               b_src.vld = 0;
            end
            cyc++;
         end
         b_src.vld = 0;
         checks++;
         if (got != 1000) begin
            errors++;
            $display("FAIL sweep_count_pass%0d: got %0d beats required 1000", pass, got);
         end
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_streaming();
      test_backpressure();
      test_reset_midstream();
      test_param_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
